// File: rtl/rr_reg_arbiter.sv
// rtl/rr_reg_arbiter.sv - round-robin ownership arbiter for one shared W-bit register
//
// Purpose:
//   Grants one of NREQ requesters ownership of a shared W-bit register. Only the
//   owner's data is loaded. A hold counter forces rotation after MAX_HOLD
//   consecutive writes, so a busy requester cannot starve the others.
//
// Ports:
//   clk     in   1             clock, rising edge
//   reset   in   1             asynchronous reset, active-high
//   req     in   NREQ          level request per requester
//   wdata   in   NREQ*W        requester i data at [i*W +: W]
//   gnt     out  NREQ          one-hot grant (or zero), registered
//   gnt_id  out  clog2(NREQ)   index of current owner; holds last owner while idle
//   busy    out  1             high while in OWN
//   q       out  W             shared register contents
//   q_upd   out  1             high in the cycle after q was loaded
module rr_reg_arbiter #(
    parameter int NREQ     = 4,
    parameter int W        = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*W-1:0]        wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [$clog2(NREQ)-1:0]  gnt_id,
    output logic                     busy,
    output logic [W-1:0]             q,
    output logic                     q_upd
);

    localparam int IW = $clog2(NREQ);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic {IDLE, OWN} state_t;

    state_t          state, state_n;
    logic [NREQ-1:0] gnt_n;
    logic [IW-1:0]   gnt_id_n;
    logic [IW-1:0]   ptr, ptr_n;
    logic [HW-1:0]   hold_cnt, hold_n;
    logic [W-1:0]    q_n;
    logic            q_upd_n;
    logic [IW:0]     sel;
    logic [IW-1:0]   rot;
    logic [W-1:0]    own_data;

    // Returns {found, index}: first set bit of r scanning start, start+1, ...
    // modulo NREQ. Scanning k from high to low lets the lowest offset win.
    function automatic logic [IW:0] pick(input logic [NREQ-1:0] r,
                                         input logic [IW-1:0]   start);
        logic          found;
        logic [IW-1:0] win;
        logic [IW:0]   sum;
        found = 1'b0;
        win   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, start} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ))
                sum = sum - (IW+1)'(NREQ);
            if (r[sum[IW-1:0]]) begin
                found = 1'b1;
                win   = sum[IW-1:0];
            end
        end
        return {found, win};
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [NREQ-1:0] o;
        o      = '0;
        o[idx] = 1'b1;
        return o;
    endfunction

    // Pointer position just past the current owner.
    assign rot  = (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + IW'(1);
    assign busy = (state == OWN);

    always_comb begin
        own_data = '0;
        for (int i = 0; i < NREQ; i++)
            if (gnt_id == IW'(i))
                own_data = wdata[i*W +: W];
    end

    always_comb begin
        state_n  = state;
        gnt_n    = gnt;
        gnt_id_n = gnt_id;
        ptr_n    = ptr;
        hold_n   = hold_cnt;
        q_n      = q;
        q_upd_n  = 1'b0;
        sel      = '0;
        case (state)
            IDLE: begin
                sel = pick(req, ptr);
                if (sel[IW]) begin
                    state_n  = OWN;
                    gnt_n    = onehot(sel[IW-1:0]);
                    gnt_id_n = sel[IW-1:0];
                    hold_n   = '0;
                end
            end
            OWN: begin
                if (req[gnt_id]) begin
                    q_n     = own_data;
                    q_upd_n = 1'b1;
                    if (hold_cnt == HW'(MAX_HOLD - 1)) begin
                        // Forced rotation: the owner is excluded; if nobody
                        // else is waiting it simply keeps the grant.
                        ptr_n  = rot;
                        hold_n = '0;
                        sel    = pick(req & ~onehot(gnt_id), rot);
                        if (sel[IW]) begin
                            gnt_n    = onehot(sel[IW-1:0]);
                            gnt_id_n = sel[IW-1:0];
                        end
                    end else begin
                        hold_n = hold_cnt + HW'(1);
                    end
                end else begin
                    // Release: hand over on the same edge when possible.
                    ptr_n  = rot;
                    hold_n = '0;
                    sel    = pick(req, rot);
                    if (sel[IW]) begin
                        gnt_n    = onehot(sel[IW-1:0]);
                        gnt_id_n = sel[IW-1:0];
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            q        <= '0;
            q_upd    <= 1'b0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            gnt_id   <= gnt_id_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
            q        <= q_n;
            q_upd    <= q_upd_n;
        end
    end

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// tb/tb_rr_reg_arbiter.sv - directed scoreboard bench for rr_reg_arbiter
module tb_rr_reg_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] wdata;
    logic [NREQ-1:0]   gnt;
    logic [1:0]        gnt_id;
    logic              busy;
    logic [W-1:0]      q;
    logic              q_upd;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] sb[$];

    rr_reg_arbiter #(.NREQ(NREQ), .W(W), .MAX_HOLD(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .wdata  (wdata),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy),
        .q      (q),
        .q_upd  (q_upd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then sample 1 ns later. A write is expected in this
    // cycle exactly when the scoreboard holds a pending value.
    task automatic tick();
        logic [W-1:0] e;
        @(posedge clk);
        #1;
        chk("q_upd", {31'b0, q_upd}, {31'b0, sb.size() != 0});
        if (q_upd === 1'b1 && sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_q", {28'b0, q}, {28'b0, e});
        end
        chk("gnt_onehot", {31'b0, $countones(gnt) <= 1}, 32'd1);
        chk("busy_vs_gnt", {31'b0, busy}, {31'b0, |gnt});
    endtask

    initial begin
        logic [W-1:0] v;
        reset = 1'b1;
        req   = '0;
        wdata = '0;
        #1;
        chk("rst_gnt", {28'b0, gnt}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_q", {28'b0, q}, 32'h0);
        chk("rst_q_upd", {31'b0, q_upd}, 32'h0);
        chk("rst_gnt_id", {30'b0, gnt_id}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        tick();

        // Single requester
        req = 4'b0010;
        wdata[1*W +: W] = 4'hA;
        tick();
        chk("single_gnt", {28'b0, gnt}, 32'b0010);
        chk("single_gnt_id", {30'b0, gnt_id}, 32'd1);
        sb.push_back(4'hA);
        tick();
        chk("single_q", {28'b0, q}, 32'hA);
        req = '0;
        tick();
        chk("single_idle_gnt", {28'b0, gnt}, 32'h0);
        chk("single_hold_q", {28'b0, q}, 32'hA);
        chk("single_idle_id", {30'b0, gnt_id}, 32'd1);

        // Simultaneous requests from reset: order 0,1,2,3, no idle gap
        reset = 1'b1;
        #1;
        reset = 1'b0;
        wdata = 16'h8421;
        req   = 4'b1111;
        tick();
        for (int i = 0; i < NREQ; i++) begin
            chk($sformatf("rr_gnt%0d", i), {28'b0, gnt}, 32'(1 << i));
            chk($sformatf("rr_busy%0d", i), {31'b0, busy}, 32'd1);
            sb.push_back(wdata[i*W +: W]);
            tick();
            req[i] = 1'b0;
            tick();
        end
        chk("rr_end_idle", {31'b0, busy}, 32'd0);

        // Hold cap: 0 writes 4 times, then 2 takes over (ptr was 0)
        wdata[0*W +: W] = 4'h5;
        wdata[2*W +: W] = 4'h6;
        req = 4'b0101;
        tick();
        chk("cap_first_gnt", {28'b0, gnt}, 32'b0001);
        for (int i = 0; i < 4; i++) begin
            sb.push_back(4'h5);
            tick();
            chk($sformatf("cap_gnt%0d", i), {28'b0, gnt}, (i < 3) ? 32'b0001 : 32'b0100);
        end

        // Reset mid-OWN while 2 owns: immediate clear, ptr back to 0
        reset = 1'b1;
        #2;
        chk("mid_rst_gnt", {28'b0, gnt}, 32'h0);
        chk("mid_rst_q", {28'b0, q}, 32'h0);
        chk("mid_rst_busy", {31'b0, busy}, 32'h0);
        reset = 1'b0;
        req   = 4'b1001;
        tick();
        chk("post_rst_gnt", {28'b0, gnt}, 32'b0001);
        req = '0;
        tick();
        chk("post_rst_idle", {28'b0, gnt}, 32'h0);

        // Lone long holder (ptr=1, search wraps to 0)
        wdata[0*W +: W] = 4'h7;
        req = 4'b0001;
        tick();
        for (int i = 0; i < 10; i++) begin
            sb.push_back(4'h7);
            tick();
            chk($sformatf("lone_gnt%0d", i), {28'b0, gnt}, 32'b0001);
        end
        req = '0;
        tick();

        // Non-owner data noise while 1 owns
        wdata[1*W +: W] = 4'h9;
        req = 4'b0010;
        tick();
        chk("noise_gnt", {28'b0, gnt}, 32'b0010);
        for (int i = 0; i < 6; i++) begin
            v = W'(i + 3);
            wdata[1*W +: W] = v;
            wdata[3*W +: W] = W'($urandom_range(15, 0));
            sb.push_back(v);
            tick();
            chk($sformatf("noise_gnt%0d", i), {28'b0, gnt}, 32'b0010);
        end
        req = '0;
        tick();
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
